// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants, state encoding and out-word layout for the OCI DCT packer.
// Word layout: {count[CNT_W-1:0], buffer[BUF_W-1:0]}, atom i at buffer bits 2i.
package nios2_oci_dct_pkg;

    localparam int ATOM_W = 2;
    localparam int ATOMS = 15;
    localparam int CNT_W = 4;
    localparam int EMIT_W = 16;
    localparam int BUF_W = ATOM_W * ATOMS;
    localparam int OUT_W = CNT_W + BUF_W;
    localparam int OUT_CNT_LSB = BUF_W;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_PFLUSH,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } dct_state_e;

    function automatic logic [OUT_W-1:0] out_word(
        input logic [CNT_W-1:0] cnt,
        input logic [BUF_W-1:0] buffer
    );
        logic [OUT_W-1:0] w;
        w = '0;
        w[OUT_CNT_LSB +: CNT_W] = cnt;
        w[BUF_W-1:0] = buffer;
        return w;
    endfunction

endpackage

// File: rtl/nios2_oci_dct_pack_ctrl_if.sv
// Atom input and trace-word output handshakes of the DCT packer.
// master: atom source / trace sink side; slave: the packer.
interface nios2_oci_dct_pack_ctrl_if;
    import nios2_oci_dct_pkg::*;

    logic              atom_valid;
    logic [ATOM_W-1:0] atom_data;
    logic              atom_ready;
    logic              flush;
    logic              test_ending;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              out_ready;

    modport master (
        output atom_valid, atom_data, flush, test_ending, out_ready,
        input  atom_ready, out_valid, out_data
    );

    modport slave (
        input  atom_valid, atom_data, flush, test_ending, out_ready,
        output atom_ready, out_valid, out_data
    );

endinterface

// File: rtl/nios2_oci_dct_out_slot.sv
// One-entry valid/ready holding register for packed trace words.
// Ports: load/load_data fill it, out_* drain it, slot_free = may load this edge.
module nios2_oci_dct_out_slot
    import nios2_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [OUT_W-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             slot_free
);

    assign slot_free = !out_valid || out_ready;

    // load is only raised while slot_free, so a held word never changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nios2_oci_dct_pack_ctrl.sv
// DCT packer: packs 2-bit atoms into a 30-bit buffer, emits full/flushed words,
// runs end-of-test drain. Ports: clk, reset, bus (atoms in, words out), observation.
module nios2_oci_dct_pack_ctrl
    import nios2_oci_dct_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    nios2_oci_dct_pack_ctrl_if.slave bus,
    output logic [BUF_W-1:0]         dct_buffer,
    output logic [CNT_W-1:0]         dct_count,
    output logic                     test_has_ended,
    output logic [EMIT_W-1:0]        words_emitted
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(ATOMS);

    dct_state_e       state;
    logic             slot_free;
    logic             accept;
    logic             pack;
    logic [BUF_W-1:0] buf_acc;
    logic [CNT_W-1:0] cnt_acc;
    logic [OUT_W-1:0] pack_word;

    // gated by reset so every output reads 0 while reset is held
    assign bus.atom_ready = !reset && (state == ST_RUN)
                          && (dct_count < FULL);
    assign accept = bus.atom_valid && bus.atom_ready;

    // buffer/count including this edge's accepted atom
    always_comb begin
        buf_acc = dct_buffer;
        cnt_acc = dct_count;
        if (accept) begin
            buf_acc[int'(dct_count) * ATOM_W +: ATOM_W] = bus.atom_data;
            cnt_acc = dct_count + 1'b1;
        end
    end

    always_comb begin
        pack = 1'b0;
        case (state)
            ST_RUN:    pack = (cnt_acc == FULL) && slot_free;
            ST_PFLUSH: pack = !bus.test_ending && slot_free;
            ST_FLUSH:  pack = (dct_count != '0) && slot_free;
            default:   pack = 1'b0;
        endcase
    end

    assign pack_word = out_word(cnt_acc, buf_acc);

    nios2_oci_dct_out_slot u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (pack),
        .load_data (pack_word),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .slot_free (slot_free)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_RUN;
            dct_buffer     <= '0;
            dct_count      <= '0;
            test_has_ended <= 1'b0;
            words_emitted  <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready && (words_emitted != '1))
                words_emitted <= words_emitted + 1'b1;

            if (pack) begin
                dct_buffer <= '0;
                dct_count  <= '0;
            end else begin
                dct_buffer <= buf_acc;
                dct_count  <= cnt_acc;
            end

            case (state)
                ST_RUN: begin
                    // a full pack on a flush edge leaves nothing to flush
                    if (bus.test_ending)
                        state <= ST_FLUSH;
                    else if (bus.flush && !pack && (cnt_acc != '0))
                        state <= ST_PFLUSH;
                end
                ST_PFLUSH: begin
                    if (bus.test_ending)
                        state <= ST_FLUSH;
                    else if (slot_free)
                        state <= ST_RUN;
                end
                ST_FLUSH: begin
                    if ((dct_count == '0) || slot_free)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (slot_free) begin
                        state          <= ST_DONE;
                        test_has_ended <= 1'b1;
                    end
                end
                default: state <= ST_DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_oci_dct_pack_ctrl.sv
// Self-checking bench for nios2_oci_dct_pack_ctrl: directed scenarios plus
// random traffic compared each cycle against a queue-based reference model.
module tb_nios2_oci_dct_pack_ctrl;
    import nios2_oci_dct_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              test_has_ended;
    logic [EMIT_W-1:0] words_emitted;

    nios2_oci_dct_pack_ctrl_if bus ();

    nios2_oci_dct_pack_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended),
        .words_emitted  (words_emitted)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: pending atoms as a queue, phase as a plain int
    localparam int P_RUN = 0;
    localparam int P_PF  = 1;
    localparam int P_FL  = 2;
    localparam int P_DR  = 3;
    localparam int P_DN  = 4;

    int          q[$];
    int          ph;
    bit          m_vld;
    logic [33:0] m_word;
    int          m_words;
    bit          m_end;

    function automatic logic [29:0] m_buf();
        logic [29:0] b;
        b = '0;
        foreach (q[i]) b = b | (30'(q[i]) << (2 * i));
        return b;
    endfunction

    function automatic bit m_ready();
        return (ph == P_RUN) && (q.size() < 15);
    endfunction

    task automatic model_reset();
        q.delete();
        ph = P_RUN;
        m_vld = 0;
        m_word = '0;
        m_words = 0;
        m_end = 0;
    endtask

    task automatic m_emit();
        m_word = {4'(q.size()), m_buf()};
        q.delete();
    endtask

    task automatic model_step(input bit av, input int ad, input bit ar,
                              input bit fl, input bit te);
        bit free;
        bit ld;
        free = !m_vld || ar;
        ld = 0;
        if (m_vld && ar && m_words != 16'hFFFF) m_words++;
        case (ph)
            P_RUN: begin
                if (av && q.size() < 15) q.push_back(ad & 3);
                if (q.size() == 15 && free) begin
                    m_emit();
                    ld = 1;
                end
                if (te) ph = P_FL;
                else if (fl && q.size() > 0) ph = P_PF;
            end
            P_PF: begin
                if (te) ph = P_FL;
                else if (free) begin
                    m_emit();
                    ld = 1;
                    ph = P_RUN;
                end
            end
            P_FL: begin
                if (q.size() == 0) ph = P_DR;
                else if (free) begin
                    m_emit();
                    ld = 1;
                    ph = P_DR;
                end
            end
            P_DR: begin
                if (free) begin
                    ph = P_DN;
                    m_end = 1;
                end
            end
            default: ;
        endcase
        m_vld = ld || (m_vld && !ar);
    endtask

    task automatic check_all();
        check("out_valid", bus.out_valid, m_vld);
        check("out_data", bus.out_data, m_word);
        check("atom_ready", bus.atom_ready, m_ready());
        check("dct_count", dct_count, q.size());
        check("dct_buffer", dct_buffer, m_buf());
        check("test_has_ended", test_has_ended, m_end);
        check("words_emitted", words_emitted, m_words);
    endtask

    task automatic cyc(input bit av, input int ad, input bit ar,
                       input bit fl, input bit te);
        @(negedge clk);
        bus.atom_valid = av;
        bus.atom_data = 2'(ad);
        bus.out_ready = ar;
        bus.flush = fl;
        bus.test_ending = te;
        model_step(av, ad, ar, fl, te);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.atom_valid = 0;
        bus.atom_data = '0;
        bus.out_ready = 0;
        bus.flush = 0;
        bus.test_ending = 0;
    endtask

    task automatic reset_checks();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_atom_ready", bus.atom_ready, 0);
        check("rst_count", dct_count, 0);
        check("rst_buffer", dct_buffer, 0);
        check("rst_ended", test_has_ended, 0);
        check("rst_words", words_emitted, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    int          acc;
    int          a[15];
    logic [29:0] eb;

    initial begin
        idle_inputs();
        model_reset();
        do_reset();

        // 15 atoms cycling 0..3, sink always ready
        for (int i = 0; i < 15; i++) begin
            cyc(1, i % 4, 1, 0, 0);
            if (i == 13) check("t1_not_yet", bus.out_valid, 0);
        end
        check("t1_valid", bus.out_valid, 1);
        check("t1_word", bus.out_data, {4'd15, 30'h24E4E4E4});
        check("t1_count", dct_count, 0);
        cyc(0, 0, 1, 0, 0);
        check("t1_words", words_emitted, 1);

        // 5 atoms of 3 then partial flush
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 3, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        check("t2_word", bus.out_data, {4'd5, 30'h000003FF});
        check("t2_count", dct_count, 0);
        cyc(0, 0, 1, 0, 0);
        check("t2_run_ready", bus.atom_ready, 1);

        // 30 atoms with the sink stalled, then released
        do_reset();
        acc = 0;
        for (int n = 0; n < 40; n++) begin
            bit av;
            av = acc < 30;
            if (av && m_ready()) acc++;
            cyc(av, $urandom_range(0, 3), n >= 32, 0, 0);
            if (n == 31) begin
                check("t3_stall_ready", bus.atom_ready, 0);
                check("t3_stall_count", dct_count, 15);
                check("t3_stall_valid", bus.out_valid, 1);
            end
        end
        check("t3_words", words_emitted, 2);
        check("t3_count", dct_count, 0);

        // test_ending on the 3rd accept
        do_reset();
        for (int i = 0; i < 3; i++) a[i] = $urandom_range(0, 3);
        cyc(1, a[0], 1, 0, 0);
        cyc(1, a[1], 1, 0, 0);
        cyc(1, a[2], 1, 0, 1);
        cyc(0, 0, 0, 0, 0);
        eb = 30'(a[0] | (a[1] << 2) | (a[2] << 4));
        check("t4_valid", bus.out_valid, 1);
        check("t4_word", bus.out_data, {4'd3, eb});
        cyc(1, 1, 0, 0, 0);
        check("t4_not_ended", test_has_ended, 0);
        cyc(0, 0, 1, 0, 0);
        check("t4_ended", test_has_ended, 1);
        cyc(1, 2, 1, 1, 1);
        check("t4_refused", bus.atom_ready, 0);
        check("t4_count", dct_count, 0);

        // test_ending with nothing buffered
        do_reset();
        cyc(0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++)
            if (!test_has_ended) cyc(0, 0, 1, 0, 0);
        check("t5_ended", test_has_ended, 1);
        check("t5_words", words_emitted, 0);

        // asynchronous reset in the middle of packing
        do_reset();
        for (int i = 0; i < 22; i++) cyc(1, $urandom_range(0, 3), 0, 0, 0);
        check("t6_pre_count", dct_count, 7);
        check("t6_pre_valid", bus.out_valid, 1);
        @(negedge clk);
        #2;
        reset = 1;
        idle_inputs();
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        reset = 0;
        eb = '0;
        for (int i = 0; i < 15; i++) begin
            a[i] = $urandom_range(0, 3);
            eb = eb | (30'(a[i]) << (2 * i));
            cyc(1, a[i], 1, 0, 0);
        end
        check("t6_word", bus.out_data, {4'd15, eb});
        check("t6_words", words_emitted, 0);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (ph == P_DN && $urandom_range(0, 9) == 0) do_reset();
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3),
                $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                $urandom_range(0, 399) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
